ifetch_queue: RTL

Instruction prefetch queue between the instruction memory and the IF/ID pipeline register of the pipelined CPU. It generates sequential fetch addresses and issues one outstanding request at a time on a ready/valid memory port. It buffers returned instructions with their PCs in a small FIFO and presents them to the fetch stage with a valid/ready handshake. Branch redirects from the ID stage flush the queue and discard any in-flight response.

---
 rtl/ifetch_queue.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction prefetch queue between instruction memory and the
// IF/ID register. It issues one sequential fetch at a time, buffers returned
// words with their PCs in a circular FIFO, and flushes everything on a branch
// redirect. A response that was in flight at redirect time is dropped.
//
// Optional feature: define IFETCH_QUEUE_BYPASS_EN to present a response
// combinationally on the output port when the queue is empty.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect_valid,
  input  logic [63:0]                redirect_pc,
  output logic                       imem_req,
  output logic [63:0]                imem_addr,
  input  logic                       imem_ready,
  input  logic                       imem_rvalid,
  input  logic [31:0]                imem_rdata,
  output logic                       out_valid,
  output logic [31:0]                out_instr,
  output logic [63:0]                out_pc,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_DISCARD
  } state_e;

  state_e        state_q, state_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   instr_mem [DEPTH];
  logic [63:0]   pc_mem    [DEPTH];

  logic          fifo_valid;
  logic          bypass;
  logic          issue;
  logic          fifo_push;
  logic          fifo_pop;
  logic [63:0]   resp_pc;

  // Handshake decode and output selection.
  // NOTE: every signal written in an always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    // fetch_pc already points past the outstanding request.
    resp_pc    = fetch_pc_q - 64'd4;
    fifo_valid = (count_q != '0);
    bypass     = 1'b0;
`ifdef IFETCH_QUEUE_BYPASS_EN
    bypass     = (state_q == S_WAIT) && !fifo_valid && imem_rvalid && !redirect_valid;
`endif
    // Requests only leave FETCH, so the outstanding slot never needs counting.
    imem_req   = reset && (state_q == S_FETCH) && (count_q < FULL) && !redirect_valid;
    imem_addr  = fetch_pc_q;
    out_valid  = reset && (fifo_valid || bypass);
    out_instr  = bypass ? imem_rdata : instr_mem[rd_ptr_q];
    out_pc     = bypass ? resp_pc    : pc_mem[rd_ptr_q];

    issue      = imem_req && imem_ready;
    fifo_pop   = fifo_valid && out_ready && !redirect_valid;
    // A bypassed word that is consumed immediately never enters storage.
    fifo_push  = (state_q == S_WAIT) && imem_rvalid && !redirect_valid &&
                 !(bypass && out_ready);
  end

  // Next-state logic for the FSM, fetch address and FIFO bookkeeping.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    case (state_q)
      S_FETCH: begin
        if (issue) begin
          state_d    = S_WAIT;
          fetch_pc_d = fetch_pc_q + 64'd4;
        end
      end
      S_WAIT: begin
        // A redirect with no response yet leaves one stale reply to swallow.
        if (imem_rvalid) begin
          state_d = S_FETCH;
        end else if (redirect_valid) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (imem_rvalid) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase

    if (fifo_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({fifo_push, fifo_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Redirect overrides any same-cycle push, pop or issue.
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[63:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end
  end

  // Control state register with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its input before any of them update.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Payload storage write port.
  // NOTE: the storage array is deliberately not reset; count_q gates
  // out_valid, so unwritten entries are never presented.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]    <= resp_pc;
    end
  end

  assign count = count_q;

endmodule
